serial_addsub_ctrl: RTL and testbench

//  Bit-serial sequencer for the single-bit add/sub cell (add_sub). It runs one
//  add_sub instance LSB-first over WIDTH-bit operands and keeps the carry in a

---
 rtl/serial_addsub_ctrl.sv | 153 +++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer driving one add_sub cell LSB-first over WIDTH bits.
// Define SERIAL_ADDSUB_ZFLAG_EN to add a registered 'zero' result flag output.

module add_sub (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sel,
  output logic sum,
  output logic cout
);

  logic bx;

  // Subtraction inverts b; the +1 comes in through cin from the sequencer.
  assign bx   = b ^ sel;
  assign sum  = a ^ bx ^ cin;
  assign cout = (a & bx) | (cin & (a ^ bx));

endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
`ifdef SERIAL_ADDSUB_ZFLAG_EN
  ,
  output logic             zero
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_final;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             sel_q;
  logic             load;
  logic             step;
  logic             last;
  logic             bit_sum;
  logic             bit_cout;

  add_sub u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sel  (sel_q),
    .sum  (bit_sum),
    .cout (bit_cout)
  );

  assign last      = (cnt == CNT_W'(WIDTH - 1));
  assign res_final = {bit_sum, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Visible outputs only move on the final bit, so they hold through IDLE and the next RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sel_q    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
      zero     <= 1'b0;
`endif
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      sel_q <= sel;
      carry <= sel;
      cnt   <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_final;
      carry  <= bit_cout;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        result   <= res_final;
        cout     <= bit_cout;
        overflow <= carry ^ bit_cout;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
        zero     <= (res_final == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: arithmetic reference model plus directed and random ops.
// Define SERIAL_ADDSUB_ZFLAG_EN to also check the zero flag.

module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
  logic         zero;
`endif

  int errors = 0;
  int checks = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sel      (sel),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    ,
    .zero     (zero)
`endif
  );

  always #5 clk = ~clk;

  // Reference arithmetic: plain integer add/sub, then range checks for carry and signed overflow.
  function automatic logic [W-1:0] refRes(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int ux = int'(x);
    int uy = int'(y);
    return W'(s ? ux - uy : ux + uy);
  endfunction

  function automatic logic refCout(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int ux = int'(x);
    int uy = int'(y);
    return s ? (ux >= uy) : (ux + uy > 255);
  endfunction

  function automatic logic refOvf(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int sr = s ? sx - sy : sx + sy;
    return (sr > 127) || (sr < -128);
  endfunction

  // t counts cycles since the accepting edge: 0..W-1 busy, W done, -1 idle.
  int           t = -1;
  logic [W-1:0] p_res = '0;
  logic         p_cout = 1'b0;
  logic         p_ovf = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_zero = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t      <= -1;
      m_res  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
      m_zero <= 1'b0;
    end else if (t < 0) begin
      if (start === 1'b1) begin
        t      <= 0;
        p_res  <= refRes(sel, a, b);
        p_cout <= refCout(sel, a, b);
        p_ovf  <= refOvf(sel, a, b);
      end
    end else if (t == W - 1) begin
      t      <= W;
      m_res  <= p_res;
      m_cout <= p_cout;
      m_ovf  <= p_ovf;
      m_zero <= (p_res == '0);
    end else if (t == W) begin
      t <= -1;
    end else begin
      t <= t + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("cyc_busy", 32'(busy), 32'(t >= 0 && t < W));
    checkOutput("cyc_done", 32'(done), 32'(t == W));
    checkOutput("cyc_result", 32'(result), 32'(m_res));
    checkOutput("cyc_cout", 32'(cout), 32'(m_cout));
    checkOutput("cyc_overflow", 32'(overflow), 32'(m_ovf));
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    checkOutput("cyc_zero", 32'(zero), 32'(m_zero));
`endif
  end

  // Issues one start, then scrambles the operand inputs so the running op must ignore them.
  task automatic applyStimulus(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    #1;
    start = 1'b1;
    sel   = s;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    sel   = 1'($urandom);
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  task automatic waitDone(input string name, output int busy_cycles);
    int n;
    busy_cycles = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) break;
    end
    checkOutput({name, "_done_seen"}, 32'(n < 40), 32'd1);
  endtask

  task automatic runOp(input string name, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic ec, input logic ev);
    int nb;
    applyStimulus(s, x, y);
    waitDone(name, nb);
    checkOutput({name, "_busy_cycles"}, 32'(nb), 32'(W));
    checkOutput({name, "_result"}, 32'(result), 32'(er));
    checkOutput({name, "_cout"}, 32'(cout), 32'(ec));
    checkOutput({name, "_overflow"}, 32'(overflow), 32'(ev));
    checkOutput({name, "_model"}, 32'(m_res), 32'(er));
  endtask

  initial begin
    int nb;
    int dones;
    rst_n = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    a     = '0;
    b     = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    runOp("add_100_27", 1'b0, 8'd100, 8'd27, 8'd127, 1'b0, 1'b0);
    runOp("sub_5_7", 1'b1, 8'd5, 8'd7, 8'hFE, 1'b0, 1'b0);
    runOp("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    runOp("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Start re-pulsed with new operands while running: must be ignored, one done only.
    applyStimulus(1'b0, 8'd50, 8'd20);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      sel   = 1'b1;
      a     = W'($urandom);
      b     = W'($urandom);
    end
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("midrun_dones", 32'(dones), 32'd1);
    checkOutput("midrun_result", 32'(result), 32'h46);
    runOp("after_midrun", 1'b0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0);
    runOp("back_to_back", 1'b0, 8'd50, 8'd20, 8'h46, 1'b0, 1'b0);

    // Reset in the middle of an op clears everything at once and suppresses done.
    applyStimulus(1'b0, 8'h33, 8'h44);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    checkOutput("abort_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("abort_no_done", 32'(dones), 32'd0);
    runOp("after_abort", 1'b1, 8'd200, 8'd55, 8'h91, 1'b1, 1'b0);

`ifdef SERIAL_ADDSUB_ZFLAG_EN
    runOp("sub_42_42", 1'b1, 8'd42, 8'd42, 8'd0, 1'b1, 1'b0);
    checkOutput("sub_42_42_zero", 32'(zero), 32'd1);
    runOp("add_1_1", 1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0);
    checkOutput("add_1_1_zero", 32'(zero), 32'd0);
`endif

    // Random traffic: start, sel and operands change every cycle; the model decides what is accepted.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 2) == 0);
      sel   = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
    end
    @(posedge clk);
    #1 start = 1'b0;
    waitDone("drain", nb);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
